uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  - Shares one uart_tx instance among N byte requesters using round-robin arbitration.
//  - Sequences the transmitter: pulses tx_data_valid, then waits for tx_done before the next grant.
//  - Sits between client logic (loopback, status reporters, CLI) and uart_tx (115200 baud, 50 MHz clock).
// PARAMETERS
//  - NUM_REQ     default 4   number of requesters, 2..16
//  - DATA_WIDTH  default 8   byte width; must match uart_tx DATA_WIDTH
//  - ID_WIDTH    default 2   width of grant_id; equals $clog2(NUM_REQ)
// PORTS
//  - clk            in   1                    system clock
//  - reset          in   1                    asynchronous, active-low reset
//  - req_valid      in   NUM_REQ              per-requester byte-pending flag; level, held until ready
//  - req_data       in   NUM_REQ*DATA_WIDTH   packed bytes; requester i owns [i*DW +: DW]
//  - req_ready      out  NUM_REQ              one-hot, 1-cycle pulse; byte captured this cycle
//  - tx_data_valid  out  1                    1-cycle start pulse to uart_tx
//  - tx_byte        out  DATA_WIDTH           byte to uart_tx; stable from the pulse until tx_done
//  - tx_busy        in   1                    uart_tx busy
//  - tx_done        in   1                    uart_tx 1-cycle end-of-frame pulse
//  - grant_id       out  ID_WIDTH             index of the current or last granted requester
//  - arb_busy       out  1                    high whenever state != IDLE
// BEHAVIOUR
//  - Reset values: req_ready=0, tx_data_valid=0, tx_byte=0, grant_id=0, arb_busy=0, rr_ptr=0, state=IDLE.
//  - FSM states: IDLE, GRANT, [TAG_START, TAG_WAIT], START, WAIT.
//  - IDLE: if |req_valid, go to GRANT on the next edge.
//  - GRANT (1 cycle):
//    - Round-robin pick: first i with req_valid[i], scanning from rr_ptr upward and wrapping at NUM_REQ-1 -> 0.
//    - Pulse req_ready[i]; capture req_data slice i into hold_q; set grant_id=i.
//    - Set rr_ptr = (i+1) mod NUM_REQ.
//    - If req_valid drops before GRANT, go to IDLE with no pulse.
//  - START:
//    - Wait while tx_busy=1.
//    - When tx_busy=0, drive tx_data_valid=1 for exactly 1 cycle with tx_byte=hold_q, then go to WAIT.
//  - WAIT:
//    - Stay until tx_done=1, then go to IDLE.
//    - tx_done seen in any other state is ignored.
//  - Latency: req_valid rise -> req_ready pulse = 2 cycles. req_ready -> tx_data_valid = 1 cycle (tx idle).
//  - Back-to-back requests: the next grant occurs 2 cycles after tx_done.
//  - A requester may re-assert req_valid with a new byte the cycle after its ready pulse. Fairness is preserved by rr_ptr.
//  - Simultaneous requests: the lowest index at or above rr_ptr wins. No starvation: worst-case wait is NUM_REQ-1 frames.
//  - req_data is sampled only in GRANT; changes outside GRANT have no effect.
//  - Reset mid-frame: all state clears immediately. The uart_tx frame in flight is uart_tx's concern. No ready pulse is lost or duplicated.
// CONFIGURATION
//  - Macro UART_ARB_SRC_TAG_EN.
//  - Defined:
//    - GRANT goes to TAG_START; a tag byte {4'hA, 4'(grant_id)} is sent first.
//    - TAG_START/TAG_WAIT mirror START/WAIT.
//    - The data byte then follows via START/WAIT. Two frames are sent per grant.
//    - Requires NUM_REQ <= 16.
//  - Undefined: TAG states are absent; GRANT goes directly to START; one frame per grant.
// STRUCTURE
//  - Package uart_pkg:
//    - state enum arb_state_t.
//    - TAG_PREFIX = 4'hA.
//    - default DATA_WIDTH = 8.
//    - CLK_FREQ/BAUD_RATE constants shared with uart_rx/uart_tx.
//  - Sub-module rr_arbiter: combinational pick from (req_valid, rr_ptr) to one-hot grant plus index. The rr_ptr register stays in the parent.
//  - Parent holds the FSM, hold_q, rr_ptr and the output registers.
// TESTING
//  - Stimulus uses the uart_tx model with tx_busy and a 1-cycle tx_done after a programmable 20 cycles.
//  - Single requester: req_valid[2]=1, data 8'h5A
//    -> req_ready[2] pulses once; tx_byte=8'h5A with one tx_data_valid pulse; grant_id=2.
//  - All 4 requesting, bytes 8'h10..8'h13, held continuously
//    -> transmit order 10,11,12,13,10; exactly one ready pulse per frame.
//  - rr_ptr=3 with req 0 and 3 both valid -> 3 is granted first, then 0.
//  - tx_busy held high 50 cycles at START -> tx_data_valid is delayed until tx_busy falls; no early pulse.
//  - Reset asserted in WAIT -> all outputs 0 next cycle; after release, a pending req_valid is granted again from rr_ptr=0.
//  - With UART_ARB_SRC_TAG_EN, req 1 sending 8'hC3 -> frames 8'hA1 then 8'hC3; a single req_ready pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: UART constants shared with uart_rx/uart_tx and the arbiter state encoding.
// UART_ARB_SRC_TAG_EN adds the tag-frame states.
package uart_pkg;
   localparam int CLK_FREQ       = 50_000_000;
   localparam int BAUD_RATE      = 115_200;
   localparam int DATA_WIDTH_DEF = 8;
   localparam logic [3:0] TAG_PREFIX = 4'hA;
`ifdef UART_ARB_SRC_TAG_EN
   typedef enum logic [2:0] {IDLE, GRANT, TAG_START, TAG_WAIT, START, WAIT} arb_state_t;
`else
   typedef enum logic [2:0] {IDLE, GRANT, START, WAIT} arb_state_t;
`endif
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; first requester at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] idx
);
   logic [NUM_REQ-1:0] cand;
   // scan from the far end so the lowest offset from ptr is the last writer
   always_comb begin
      grant = '0;
      idx   = '0;
      cand  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = NUM_REQ'(1) << ((int'(ptr) + k) % NUM_REQ);
         if (|(req & cand)) begin
            grant = cand;
            idx   = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte requesters.
// Optional UART_ARB_SRC_TAG_EN sends a {4'hA, grant_id} tag frame ahead of each data byte.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx_data_valid,
   output logic [DATA_WIDTH-1:0]         tx_byte,
   input  logic                          tx_busy,
   input  logic                          tx_done,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          arb_busy
);
   arb_state_t state, state_d;
   logic [NUM_REQ-1:0] pick, req_ready_d;
   logic [ID_WIDTH-1:0] pick_idx, rr_ptr, rr_ptr_d, grant_id_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d, tx_byte_d;
   logic take, fire;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (pick),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         hold_q        <= '0;
         req_ready     <= '0;
         tx_data_valid <= 1'b0;
         tx_byte       <= '0;
         grant_id      <= '0;
      end else begin
         state         <= state_d;
         rr_ptr        <= rr_ptr_d;
         hold_q        <= hold_d;
         req_ready     <= req_ready_d;
         tx_data_valid <= fire;
         tx_byte       <= tx_byte_d;
         grant_id      <= grant_id_d;
      end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:      state_d = |req_valid ? GRANT : IDLE;
`ifdef UART_ARB_SRC_TAG_EN
         GRANT:     state_d = |req_valid ? TAG_START : IDLE;
         TAG_START: state_d = tx_busy ? TAG_START : TAG_WAIT;
         TAG_WAIT:  state_d = tx_done ? START : TAG_WAIT;
`else
         GRANT:     state_d = |req_valid ? START : IDLE;
`endif
         START:     state_d = tx_busy ? START : WAIT;
         WAIT:      state_d = tx_done ? IDLE : WAIT;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      take        = state == GRANT && |req_valid;
      req_ready_d = take ? pick : '0;
      hold_d      = take ? req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH] : hold_q;
      grant_id_d  = take ? pick_idx : grant_id;
      rr_ptr_d    = !take ? rr_ptr : pick_idx == ID_WIDTH'(NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
`ifdef UART_ARB_SRC_TAG_EN
      fire        = (state == START || state == TAG_START) && !tx_busy;
      tx_byte_d   = !fire ? tx_byte :
                    state == TAG_START ? DATA_WIDTH'({TAG_PREFIX, 4'(grant_id)}) : hold_q;
`else
      fire        = state == START && !tx_busy;
      tx_byte_d   = fire ? hold_q : tx_byte;
`endif
   end

   assign arb_busy = state != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a uart_tx timing model and directed round-robin scenarios.
// Honours UART_ARB_SRC_TAG_EN (two frames per grant).
module tb_uart_tx_arbiter;
   import uart_pkg::*;
   localparam int N = 4, DW = 8, IW = 2, FRAME = 20;
`ifdef UART_ARB_SRC_TAG_EN
   localparam int FPG = 2;
`else
   localparam int FPG = 1;
`endif

   logic clk = 0, reset = 0;
   logic [N-1:0] req_valid = '0, req_ready, drop_mask = '0;
   logic [N*DW-1:0] req_data = '0;
   logic tx_data_valid, arb_busy;
   logic [DW-1:0] tx_byte;
   logic busy_m = 0, force_busy = 0, tx_done = 0, tx_busy;
   logic [IW-1:0] grant_id;

   assign tx_busy = busy_m | force_busy;
   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .tx_data_valid (tx_data_valid),
      .tx_byte       (tx_byte),
      .tx_busy       (tx_busy),
      .tx_done       (tx_done),
      .grant_id      (grant_id),
      .arb_busy      (arb_busy)
   );

   int checks = 0, fails = 0;
   logic [DW-1:0] exp_q[$], frames[$];
   int readies[$];
   int m_ptr = 0, cnt = 0, e, lat, base, rbase;
   bit in_flight = 0, prev_busy = 0;
   logic [DW-1:0] last_byte = '0;
   logic [N-1:0] prev_valid = '0;
   logic [N*DW-1:0] prev_data = '0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(req_ready & drop_mask);
   endtask

   task automatic do_reset;
      reset = 0;
      step;
      step;
      reset = 1;
      step;
   endtask

   task automatic wait_frames(input int n);
      int b = 0;
      while (frames.size() - base < n && b < 400) begin
         step;
         b++;
      end
      chk("frame_timeout", int'(b < 400), 1);
   endtask

   task automatic settle;
      int b = 0;
      while ((arb_busy || tx_busy) && b < 300) begin
         step;
         b++;
      end
      chk("settle_timeout", int'(b < 300), 1);
      repeat (3) step;
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (!reset) begin
               chk("reset_outputs", int'({req_ready, tx_data_valid, tx_byte, grant_id, arb_busy}), 0);
               exp_q.delete();
               m_ptr = 0;
               in_flight = 0;
            end else begin
               chk("ready_onehot", int'($onehot0(req_ready)), 1);
               if (req_ready != 0) begin
                  e = -1;
                  for (int k = 0; k < N; k++)
                     if (e < 0 && prev_valid[(m_ptr + k) % N]) e = (m_ptr + k) % N;
                  chk("ready_pick", int'(req_ready), e < 0 ? 0 : 1 << e);
                  chk("grant_id", int'(grant_id), e);
                  if (e >= 0) begin
                     if (FPG == 2) exp_q.push_back(8'({4'hA, 4'(e)}));
                     exp_q.push_back(prev_data[e*DW +: DW]);
                     m_ptr = (e + 1) % N;
                     readies.push_back(e);
                  end
               end
               if (tx_data_valid) begin
                  chk("start_while_busy", int'(prev_busy), 0);
                  chk("overlapping_frame", int'(in_flight), 0);
                  chk("tx_byte", int'(tx_byte), exp_q.size() > 0 ? int'(exp_q[0]) : -1);
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
                  frames.push_back(tx_byte);
                  in_flight = 1;
                  last_byte = tx_byte;
               end else if (in_flight) chk("tx_byte_stable", int'(tx_byte), int'(last_byte));
            end
            tx_done = 0;
            if (tx_data_valid) begin
               busy_m = 1;
               cnt = FRAME;
            end else if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  busy_m = 0;
                  tx_done = 1;
               end
            end
            if (tx_done) in_flight = 0;
            prev_valid = req_valid;
            prev_data = req_data;
            prev_busy = busy_m | force_busy;
         end
      join_none

      // reset state
      repeat (3) step;
      chk("rst_arb_busy", int'(arb_busy), 0);
      chk("rst_tx_byte", int'(tx_byte), 0);
      reset = 1;
      step;

      // single requester on index 2
      do_reset;
      drop_mask = '1;
      base = frames.size();
      rbase = readies.size();
      req_data[2*DW +: DW] = 8'h5A;
      req_valid = 4'b0100;
      lat = 0;
      while (req_ready == 0 && lat < 10) begin
         step;
         lat++;
      end
      chk("t1_ready_latency", lat, 2);
      chk("t1_ready", int'(req_ready), 4'b0100);
      chk("t1_grant_id", int'(grant_id), 2);
      step;
      chk("t1_valid_latency", int'(tx_data_valid), 1);
      chk("t1_first_byte", int'(tx_byte), FPG == 2 ? 8'hA2 : 8'h5A);
      wait_frames(FPG);
      settle;
      chk("t1_frames", frames.size() - base, FPG);
      chk("t1_last_byte", int'(frames[frames.size()-1]), 8'h5A);
      chk("t1_readies", readies.size() - rbase, 1);

      // all four held continuously
      do_reset;
      drop_mask = '0;
      base = frames.size();
      rbase = readies.size();
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req_valid = '1;
      wait_frames(5 * FPG);
      req_valid = '0;
      settle;
      for (int i = 0; i < 5; i++)
         chk("t2_order", int'(frames[base + i*FPG + FPG - 1]), 8'h10 + i % 4);
      chk("t2_readies", readies.size() - rbase, 5);

      // pointer at 3 with requesters 0 and 3
      do_reset;
      drop_mask = '1;
      base = frames.size();
      req_data[2*DW +: DW] = 8'h22;
      req_valid = 4'b0100;
      wait_frames(FPG);
      settle;
      base = frames.size();
      rbase = readies.size();
      req_data[0 +: DW] = 8'hE0;
      req_data[3*DW +: DW] = 8'h33;
      req_valid = 4'b1001;
      wait_frames(2 * FPG);
      settle;
      chk("t3_first", int'(frames[base + FPG - 1]), 8'h33);
      chk("t3_second", int'(frames[base + 2*FPG - 1]), 8'hE0);
      chk("t3_first_id", readies[rbase], 3);

      // uart busy held at START
      do_reset;
      drop_mask = '1;
      base = frames.size();
      rbase = readies.size();
      force_busy = 1;
      req_data[1*DW +: DW] = 8'h77;
      req_valid = 4'b0010;
      repeat (50) step;
      chk("t4_no_early_start", frames.size() - base, 0);
      chk("t4_ready_once", readies.size() - rbase, 1);
      force_busy = 0;
      step;
      chk("t4_valid_on_release", int'(tx_data_valid), 1);
      chk("t4_first_byte", int'(tx_byte), FPG == 2 ? 8'hA1 : 8'h77);
      wait_frames(FPG);
      settle;
      chk("t4_last_byte", int'(frames[frames.size()-1]), 8'h77);

      // reset during a frame, then regrant from pointer 0
      do_reset;
      drop_mask = '0;
      base = frames.size();
      req_data[1*DW +: DW] = 8'h41;
      req_data[2*DW +: DW] = 8'h42;
      req_valid = 4'b0110;
      wait_frames(1);
      repeat (3) step;
      reset = 0;
      step;
      chk("t5_reset_clears", int'({req_ready, tx_data_valid, tx_byte, grant_id, arb_busy}), 0);
      rbase = readies.size();
      reset = 1;
      lat = 0;
      while (readies.size() == rbase && lat < 100) begin
         step;
         lat++;
      end
      chk("t5_regrant_timeout", int'(lat < 100), 1);
      chk("t5_regrant_id", readies.size() > rbase ? readies[rbase] : -1, 1);
      req_valid = '0;
      settle;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
